div_iterative: RTL

- Parametrised multi-cycle integer divider for the M-extension execute stage.
- Successor of the fixed 32-bit D_IDLE/D_INIT/D_CALC/D_SIGN divider FSM.
- Generalised in operand width (XLEN) and in quotient bits resolved per cycle.
- Adds an explicit start/valid handshake, a kill (pipeline flush) input and early-out paths for divide-by-zero and signed overflow.

---
 rtl/div_iterative_if.sv | 35 +++
 rtl/div_iterative.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_iterative_if.sv
// ---------------------------------------------------------------------------
// div_iterative_if
// Request/result bundle between the execute stage and the iterative divider.
//   start_i     request strobe, only accepted while the divider is idle
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  rs1 operand
//   divisor_i   rs2 operand
//   kill_i      pipeline flush, aborts an in-flight operation
//   busy_o      divider not idle
//   valid_o     one-cycle result strobe
//   result_o    quotient or remainder, held until the next accepted start
// master: issuing side (execute stage / bench); slave: the divider.
// ---------------------------------------------------------------------------
interface div_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             kill_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, kill_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, kill_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/div_iterative.sv
// ---------------------------------------------------------------------------
// div_iterative
// Multi-cycle restoring integer divider for the M-extension execute stage.
// Resolves UNROLL quotient bits per calculation cycle, handles signed and
// unsigned DIV/REM, and short-cuts divide-by-zero and signed overflow.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      div_iterative_if.slave (start/op/operands/kill in,
//            busy/valid/result out)
//
// State | meaning  (div_states_e)
//   D_IDLE | waiting for start_i; operands latched on acceptance
//   D_INIT | sign flags, absolute values, early-out detection
//   D_CALC | UNROLL restoring steps per cycle, counter counts down to 1
//   D_SIGN | sign fix-up, quotient/remainder select into result register
// ---------------------------------------------------------------------------
module div_iterative #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    div_iterative_if.slave bus
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0]    CNT_LOAD = CW'(N);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_INIT = 2'd1;
    localparam logic [1:0] D_CALC = 2'd2;
    localparam logic [1:0] D_SIGN = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    // quo_q holds the raw dividend after acceptance, its absolute value after
    // D_INIT, and is shifted left during D_CALC until it holds the quotient.
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [WIDTH-1:0] dvs_q,     dvs_d;
    logic [WIDTH:0]   rem_q,     rem_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bypass_q,  bypass_d;
    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] result_q,  result_d;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH:0]   calc_rem;
    logic [WIDTH-1:0] calc_quo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & quo_q[WIDTH-1];
    assign b_neg     = is_signed & dvs_q[WIDTH-1];
    assign a_abs     = a_neg ? (~quo_q + 1'b1) : quo_q;
    assign b_abs     = b_neg ? (~dvs_q + 1'b1) : dvs_q;
    assign div_zero  = (dvs_q == '0);
    assign ovf       = is_signed && (quo_q == MIN_NEG) && (dvs_q == '1);

    // Remainder is WIDTH+1 bits so the shifted-in value can exceed the
    // divisor's range without losing the top bit before the compare.
    always_comb begin
        calc_rem = rem_q;
        calc_quo = quo_q;
        for (int i = 0; i < UNROLL; i++) begin
            calc_rem = {calc_rem[WIDTH-1:0], calc_quo[WIDTH-1]};
            calc_quo = {calc_quo[WIDTH-2:0], 1'b0};
            if (calc_rem >= {1'b0, dvs_q}) begin
                calc_rem    = calc_rem - {1'b0, dvs_q};
                calc_quo[0] = 1'b1;
            end
        end
    end

    assign quo_fix = (!bypass_q && neg_quo_q) ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = (!bypass_q && neg_rem_q) ? (~rem_q[WIDTH-1:0] + 1'b1)
                                              : rem_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        bypass_d  = bypass_q;
        valid_d   = 1'b0;
        result_d  = result_q;

        case (state_q)
            D_IDLE: begin
                if (bus.start_i && !bus.kill_i) begin
                    op_d    = bus.op_i;
                    quo_d   = bus.dividend_i;
                    dvs_d   = bus.divisor_i;
                    state_d = D_INIT;
                end
            end

            D_INIT: begin
                if (bus.kill_i) begin
                    state_d = D_IDLE;
                end else begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_abs;
                    dvs_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = CNT_LOAD;
                    bypass_d  = 1'b0;
                    if (div_zero) begin
                        // Remainder is the raw dividend, never sign-corrected.
                        quo_d    = '1;
                        rem_d    = {1'b0, quo_q};
                        bypass_d = 1'b1;
                        state_d  = D_SIGN;
                    end else if (ovf) begin
                        quo_d    = MIN_NEG;
                        rem_d    = '0;
                        bypass_d = 1'b1;
                        state_d  = D_SIGN;
                    end else begin
                        state_d = D_CALC;
                    end
                end
            end

            D_CALC: begin
                if (bus.kill_i) begin
                    state_d = D_IDLE;
                end else begin
                    rem_d = calc_rem;
                    quo_d = calc_quo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = D_SIGN;
                    end
                end
            end

            D_SIGN: begin
                state_d = D_IDLE;
                if (!bus.kill_i) begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    valid_d  = 1'b1;
                end
            end

            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= D_IDLE;
            op_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bypass_q  <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            bypass_q  <= bypass_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy_o   = (state_q != D_IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule
